// File: rtl/mmv_march_c_ram_tester.sv
// mmv_march_c_ram_tester: runs a March C- test over the whole address space of an MMV slave
// and reports mismatching reads and completion as one-cycle pulses.
module mmv_march_c_ram_tester #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              start,
   output logic              ready,
   output logic              fault,
   output logic              done,
   output logic [AWIDTH-1:0] m_addr,
   output logic              m_wreq,
   output logic [DWIDTH-1:0] m_wdat,
   output logic              m_rreq,
   input  logic [DWIDTH-1:0] m_rdat,
   input  logic              m_rval,
   input  logic              m_busy
);
   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;
   state_t state, state_nxt;
   logic [2:0] elem, elem_nxt;
   logic [AWIDTH-1:0] addr, addr_nxt;
   logic desc, at_end, adv, miss;
   logic [DWIDTH-1:0] rpat;
   // E3 and E4 walk downwards; every other element walks upwards
   assign desc = elem == 3'd3 || elem == 3'd4;
   assign at_end = desc ? addr == '0 : addr == '1;
   assign rpat = (elem == 3'd2 || elem == 3'd4) ? '1 : '0;
   assign miss = state == WAIT && m_rval && m_rdat != rpat && !clear;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         elem <= '0;
         addr <= '0;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         elem <= elem_nxt;
         addr <= addr_nxt;
         fault <= miss;
      end

   always_comb begin
      state_nxt = state;
      elem_nxt = elem;
      addr_nxt = addr;
      adv = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nxt = WRITE;
            elem_nxt = '0;
            addr_nxt = '0;
         end
         WRITE: adv = !m_busy;
         READ: state_nxt = m_busy ? READ : WAIT;
         WAIT: begin
            adv = m_rval && elem == 3'd5;
            state_nxt = (m_rval && elem != 3'd5) ? WRITE : WAIT;
         end
         default: state_nxt = IDLE;
      endcase
      // the write (or E5's read) closes one address; wrap only at element boundaries
      if (adv) begin
         if (!at_end) begin
            addr_nxt = desc ? addr - AWIDTH'(1) : addr + AWIDTH'(1);
            state_nxt = elem == 3'd0 ? WRITE : READ;
         end else if (elem == 3'd5)
            state_nxt = DONE;
         else begin
            elem_nxt = elem + 3'd1;
            addr_nxt = (elem == 3'd2 || elem == 3'd3) ? '1 : '0;
            state_nxt = READ;
         end
      end
      if (clear) state_nxt = IDLE;
   end

   always_comb begin
      ready = state == IDLE;
      done = state == DONE;
      m_wreq = state == WRITE;
      m_rreq = state == READ;
      m_addr = addr;
      m_wdat = (elem == 3'd1 || elem == 3'd3) ? '1 : '0;
   end
endmodule

// File: tb/tb_mmv_march_c_ram_tester.sv
// tb_mmv_march_c_ram_tester: directed bench with a latency/busy/fault-injecting memory slave
// and a bus monitor that checks every accepted request against the March C- order.
module tb_mmv_march_c_ram_tester;
   localparam int AW = 4, DW = 16, N = 16, NOPS = 160;
   logic clk = 1'b0, reset = 1'b0, clear = 1'b0, start = 1'b0;
   logic ready, fault, done, m_wreq, m_rreq, m_rval, m_busy;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdat, m_rdat;
   int vectors = 0, miscompares = 0;
   int lat = 16;
   bit busy_en = 1'b0, inj = 1'b0;

   always #5 clk = ~clk;

   mmv_march_c_ram_tester #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk(clk), .reset(reset), .clear(clear), .start(start),
      .ready(ready), .fault(fault), .done(done),
      .m_addr(m_addr), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
      .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy)
   );

   bit ew [NOPS];
   logic [AW-1:0] ea [NOPS];
   logic [DW-1:0] ed [NOPS];

   // memory slave: fixed read latency, optional random stall, optional stuck bit0 at address 3
   logic [DW-1:0] mem [N];
   int pend = 0;
   logic [DW-1:0] pdat;
   always @(posedge clk) begin
      m_rval <= 1'b0;
      m_busy <= busy_en && ($urandom_range(0, 1) == 1);
      if (m_wreq && !m_busy)
         mem[m_addr] <= (inj && m_addr == 4'd3) ? (m_wdat & ~16'h0001) : m_wdat;
      if (m_rreq && !m_busy) begin
         pend <= lat;
         pdat <= mem[m_addr];
      end else if (pend > 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            m_rval <= 1'b1;
            m_rdat <= pdat;
         end
      end
   end

   int op_idx = 0, wr_cnt = 0, rd_cnt = 0, fault_cnt = 0, done_cnt = 0, seq_bad = 0, stab_bad = 0;
   bit hold = 1'b0, h_w;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_dat;
   always @(negedge clk) begin
      if (ready && start && !clear && reset) begin
         op_idx = 0; wr_cnt = 0; rd_cnt = 0; fault_cnt = 0; done_cnt = 0; seq_bad = 0; stab_bad = 0;
      end
      if (fault) fault_cnt++;
      if (done) done_cnt++;
      if (m_wreq && m_rreq) seq_bad++;
      if (hold && !(m_wreq === h_w && m_rreq === !h_w && m_addr === h_addr && (!h_w || m_wdat === h_dat)))
         stab_bad++;
      hold = (m_wreq || m_rreq) && m_busy && !clear && reset;
      h_w = m_wreq;
      h_addr = m_addr;
      h_dat = m_wdat;
      if ((m_wreq || m_rreq) && !m_busy && reset) begin
         if (op_idx >= NOPS || m_wreq !== ew[op_idx] || m_addr !== ea[op_idx] || (m_wreq && m_wdat !== ed[op_idx]))
            seq_bad++;
         if (m_wreq) wr_cnt++;
         else rd_cnt++;
         op_idx++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c = 0;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk({tag, "_done_timeout"}, 64'(c < budget), 1);
      @(negedge clk);
   endtask

   task automatic run_full(input string tag, input int exp_faults, input bit poke);
      pulse_start();
      chk({tag, "_ready_drop"}, 64'(ready), 0);
      if (poke) begin
         repeat (100) @(posedge clk);
         #1 start = 1'b1;
         repeat (3) @(posedge clk);
         #1 start = 1'b0;
      end
      wait_done(tag, 8000);
      chk({tag, "_writes"}, 64'(wr_cnt), 80);
      chk({tag, "_reads"}, 64'(rd_cnt), 80);
      chk({tag, "_faults"}, 64'(fault_cnt), 64'(exp_faults));
      chk({tag, "_dones"}, 64'(done_cnt), 1);
      chk({tag, "_order"}, 64'(seq_bad), 0);
      chk({tag, "_stable"}, 64'(stab_bad), 0);
      chk({tag, "_ready_end"}, 64'(ready), 1);
   endtask

   initial begin
      int k = 0;
      for (int e = 0; e < 6; e++)
         for (int i = 0; i < N; i++) begin
            if (e > 0) begin
               ew[k] = 1'b0;
               ea[k] = AW'((e == 3 || e == 4) ? N - 1 - i : i);
               ed[k] = (e == 2 || e == 4) ? '1 : '0;
               k++;
            end
            if (e < 5) begin
               ew[k] = 1'b1;
               ea[k] = AW'((e == 3 || e == 4) ? N - 1 - i : i);
               ed[k] = (e == 1 || e == 3) ? '1 : '0;
               k++;
            end
         end
      repeat (10) @(posedge clk);
      #1;
      chk("rst_ready", 64'(ready), 1);
      chk("rst_fault", 64'(fault), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_wreq", 64'(m_wreq), 0);
      chk("rst_rreq", 64'(m_rreq), 0);
      chk("rst_addr", 64'(m_addr), 0);
      chk("rst_wdat", 64'(m_wdat), 0);
      reset = 1'b1;
      run_full("clean", 0, 1'b1);
      inj = 1'b1; lat = 2;
      run_full("stuck3", 2, 1'b0);
      inj = 1'b0; busy_en = 1'b1; lat = 3;
      run_full("busy", 0, 1'b0);
      busy_en = 1'b0; lat = 16;
      pulse_start();
      for (int c = 0; c < 8000 && op_idx < 85; c++) @(negedge clk);
      chk("clr_reach_e3", 64'(op_idx >= 85), 1);
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1;
      chk("clr_ready", 64'(ready), 1);
      chk("clr_wreq", 64'(m_wreq), 0);
      chk("clr_rreq", 64'(m_rreq), 0);
      clear = 1'b0;
      repeat (40) @(negedge clk);
      chk("clr_no_done", 64'(done_cnt), 0);
      chk("clr_no_fault", 64'(fault_cnt), 0);
      run_full("after_clr", 0, 1'b0);
      pulse_start();
      repeat (50) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(ready), 1);
      chk("mid_rst_wreq", 64'(m_wreq), 0);
      chk("mid_rst_rreq", 64'(m_rreq), 0);
      chk("mid_rst_addr", 64'(m_addr), 0);
      chk("mid_rst_wdat", 64'(m_wdat), 0);
      chk("mid_rst_done", 64'(done), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (30) @(posedge clk);
      #1 chk("post_rst_ready", 64'(ready), 1);
      run_full("after_rst", 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
